// File: rtl/apb_requester.sv
// ---------------------------------------------------------------------------
// apb_requester
// Accepts one command at a time on a valid/ready interface, runs it as an
// APB4 SETUP/ACCESS transfer, and returns the read data and error status on
// a valid/ready response interface.
//
// Optional build macro: APB_REQUESTER_TIMEOUT_EN
//   When defined, an ACCESS phase that sees no pready_i for TIMEOUT_CYCLES
//   cycles ends with an error response. When not defined, ACCESS waits for
//   pready_i for as long as it takes.
// ---------------------------------------------------------------------------
module apb_requester #(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,

    // Command interface
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb_i,

    // Response interface
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_error_o,

    // APB requester interface
    output logic                    psel_o,
    output logic                    penable_o,
    output logic                    pwrite_o,
    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic [DATA_WIDTH-1:0]   pwdata_o,
    output logic [DATA_WIDTH/8-1:0] pstrb_o,
    input  logic [DATA_WIDTH-1:0]   prdata_i,
    input  logic                    pready_i,
    input  logic                    pslverr_i
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    // The timeout counter needs at least one wait cycle before it can fire
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
        $error("apb_requester: TIMEOUT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    state_e state_q;
    state_e state_d;

    logic   cmd_accept_c;
    logic   xfer_done_c;
    logic   timeout_c;

    logic   cmd_ready_d;
    logic   psel_d;
    logic   penable_d;
    logic   rsp_valid_d;

    // Command handshake and normal ACCESS completion
    assign cmd_accept_c = (state_q == ST_IDLE) && cmd_valid_i && cmd_ready_o;
    assign xfer_done_c  = (state_q == ST_ACCESS) && pready_i;

`ifdef APB_REQUESTER_TIMEOUT_EN
    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES);

    logic [CNT_WIDTH-1:0] wait_cnt_q;

    // Count ACCESS cycles without pready_i; restarts with every new command
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q <= '0;
        end else if (cmd_accept_c) begin
            wait_cnt_q <= '0;
        end else if ((state_q == ST_ACCESS) && !pready_i) begin
            wait_cnt_q <= wait_cnt_q + CNT_WIDTH'(1);
        end
    end

    // A late pready_i in the final cycle wins over the timeout
    assign timeout_c = (state_q == ST_ACCESS) && !pready_i &&
                       (wait_cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_c = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, and next values of the registered control outputs
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = 1'b0;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_accept_c) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (xfer_done_c || timeout_c) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        unique case (state_d)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
            end
            ST_SETUP: begin
                psel_d = 1'b1;
            end
            ST_ACCESS: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            ST_RESP: begin
                rsp_valid_d = 1'b1;
            end
            default: begin
                cmd_ready_d = 1'b0;
            end
        endcase
    end

    // Control outputs registered so nothing reaches them combinationally
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_ready_o <= 1'b1;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            rsp_valid_o <= 1'b0;
        end else begin
            cmd_ready_o <= cmd_ready_d;
            psel_o      <= psel_d;
            penable_o   <= penable_d;
            rsp_valid_o <= rsp_valid_d;
        end
    end

    // Latch the command; these hold through the transfer and afterwards
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwrite_o <= 1'b0;
            paddr_o  <= '0;
            pwdata_o <= '0;
            pstrb_o  <= '0;
        end else if (cmd_accept_c) begin
            pwrite_o <= cmd_write_i;
            paddr_o  <= {cmd_addr_i[ADDR_WIDTH-1:2], 2'b00};
            pstrb_o  <= cmd_write_i ? cmd_strb_i : STRB_WIDTH'(0);
            if (cmd_write_i) begin
                pwdata_o <= cmd_wdata_i;
            end
        end
    end

    // Capture the response at the end of ACCESS and hold it through RESP
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_rdata_o <= '0;
            rsp_error_o <= 1'b0;
        end else if (xfer_done_c) begin
            rsp_rdata_o <= pwrite_o ? DATA_WIDTH'(0) : prdata_i;
            rsp_error_o <= pslverr_i;
        end else if (timeout_c) begin
            rsp_rdata_o <= '0;
            rsp_error_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_apb_requester.sv
// ---------------------------------------------------------------------------
// tb_apb_requester
// Directed bench for apb_requester. Expected responses are queued when a
// command is driven and compared when the DUT presents its response.
// Define APB_REQUESTER_TIMEOUT_EN for both files to exercise the timeout.
// ---------------------------------------------------------------------------
module tb_apb_requester;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_write_i;
    logic [11:0] cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic [3:0]  cmd_strb_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_error_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [11:0] paddr_o;
    logic [31:0] pwdata_o;
    logic [3:0]  pstrb_o;
    logic [31:0] prdata_i;
    logic        pready_i;
    logic        pslverr_i;

    int   tests;
    int   failed;
    rsp_t sb_q[$];

    apb_requester #(
        .ADDR_WIDTH     (12),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_write_i (cmd_write_i),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_wdata_i (cmd_wdata_i),
        .cmd_strb_i  (cmd_strb_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_error_o (rsp_error_o),
        .psel_o      (psel_o),
        .penable_o   (penable_o),
        .pwrite_o    (pwrite_o),
        .paddr_o     (paddr_o),
        .pwdata_o    (pwdata_o),
        .pstrb_o     (pstrb_o),
        .prdata_i    (prdata_i),
        .pready_i    (pready_i),
        .pslverr_i   (pslverr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a command (called at a falling edge)
    task automatic drive_cmd(input logic w, input logic [11:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        cmd_valid_i = 1'b1;
        cmd_write_i = w;
        cmd_addr_i  = a;
        cmd_wdata_i = d;
        cmd_strb_i  = s;
    endtask

    // Wait (bounded) for a response and compare it against the scoreboard head
    task automatic wait_rsp(input string tag);
        int   n;
        rsp_t e;
        n = 0;
        while (rsp_valid_o !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'd1);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_nonempty"}, 64'(sb_q.size()), 64'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_rdata"}, 64'(rsp_rdata_o), 64'(e.rdata));
            check({tag, "_error"}, 64'(rsp_error_o), 64'(e.err));
        end
    endtask

    initial begin
        int n;
        tests       = 0;
        failed      = 0;
        reset_n     = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_write_i = 1'b0;
        cmd_addr_i  = '0;
        cmd_wdata_i = '0;
        cmd_strb_i  = '0;
        rsp_ready_i = 1'b1;
        prdata_i    = '0;
        pready_i    = 1'b1;
        pslverr_i   = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
        check("rst_psel",      64'(psel_o),      64'd0);
        check("rst_penable",   64'(penable_o),   64'd0);
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("rst_paddr",     64'(paddr_o),     64'd0);
        check("rst_rdata",     64'(rsp_rdata_o), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // 1: write, zero wait states
        check("t1_cmd_ready", 64'(cmd_ready_o), 64'd1);
        drive_cmd(1'b1, 12'h008, 32'h0000_001B, 4'hF);
        sb_q.push_back(rsp_t'{rdata: 32'h0, err: 1'b0});
        @(negedge clk);
        cmd_valid_i = 1'b0;
        check("t1_setup_psel",    64'(psel_o),      64'd1);
        check("t1_setup_penable", 64'(penable_o),   64'd0);
        check("t1_setup_ready",   64'(cmd_ready_o), 64'd0);
        check("t1_paddr",         64'(paddr_o),     64'h008);
        check("t1_pstrb",         64'(pstrb_o),     64'hF);
        check("t1_pwrite",        64'(pwrite_o),    64'd1);
        check("t1_pwdata",        64'(pwdata_o),    64'h1B);
        @(negedge clk);
        check("t1_access_psel",    64'(psel_o),    64'd1);
        check("t1_access_penable", 64'(penable_o), 64'd1);
        @(negedge clk);
        check("t1_latency_valid", 64'(rsp_valid_o), 64'd1);
        check("t1_resp_psel",     64'(psel_o),      64'd0);
        check("t1_resp_penable",  64'(penable_o),   64'd0);
        wait_rsp("t1");
        @(negedge clk);
        check("t1_idle_valid", 64'(rsp_valid_o), 64'd0);
        check("t1_idle_ready", 64'(cmd_ready_o), 64'd1);

        // 2: read, zero wait states; pwdata must keep the previous write data
        prdata_i = 32'h0000_0005;
        drive_cmd(1'b0, 12'h010, 32'hDEAD_BEEF, 4'hF);
        sb_q.push_back(rsp_t'{rdata: 32'h5, err: 1'b0});
        @(negedge clk);
        cmd_valid_i = 1'b0;
        check("t2_pwrite", 64'(pwrite_o), 64'd0);
        check("t2_pstrb",  64'(pstrb_o),  64'd0);
        check("t2_paddr",  64'(paddr_o),  64'h010);
        check("t2_pwdata", 64'(pwdata_o), 64'h1B);
        @(negedge clk);
        check("t2_penable", 64'(penable_o), 64'd1);
        @(negedge clk);
        check("t2_latency_valid", 64'(rsp_valid_o), 64'd1);
        wait_rsp("t2");
        @(negedge clk);

        // 3: three wait states, then completion with pslverr
        pready_i = 1'b0;
        drive_cmd(1'b1, 12'h020, 32'hA5A5_A5A5, 4'h3);
        sb_q.push_back(rsp_t'{rdata: 32'h0, err: 1'b1});
        @(negedge clk);
        cmd_valid_i = 1'b0;
        cmd_wdata_i = 32'h0;
        cmd_addr_i  = 12'hFFF;
        check("t3_setup_psel",    64'(psel_o),    64'd1);
        check("t3_setup_penable", 64'(penable_o), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t3_penable", 64'(penable_o), 64'd1);
            check("t3_paddr",   64'(paddr_o),   64'h020);
            check("t3_pwdata",  64'(pwdata_o),  64'hA5A5_A5A5);
            check("t3_pstrb",   64'(pstrb_o),   64'h3);
            if (i == 3) begin
                pready_i  = 1'b1;
                pslverr_i = 1'b1;
            end
        end
        @(negedge clk);
        pslverr_i = 1'b0;
        check("t3_resp_penable", 64'(penable_o), 64'd0);
        check("t3_resp_psel",    64'(psel_o),    64'd0);
        wait_rsp("t3");
        @(negedge clk);

        // 4: response backpressure with a second command held pending
        rsp_ready_i = 1'b0;
        prdata_i    = 32'h0000_0077;
        drive_cmd(1'b0, 12'h004, 32'h0, 4'hF);
        sb_q.push_back(rsp_t'{rdata: 32'h77, err: 1'b0});
        @(negedge clk);
        drive_cmd(1'b1, 12'h030, 32'h1234_5678, 4'hF);
        sb_q.push_back(rsp_t'{rdata: 32'h0, err: 1'b0});
        check("t4_busy_ready", 64'(cmd_ready_o), 64'd0);
        @(negedge clk);
        @(negedge clk);
        prdata_i = 32'h0000_0099;
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", 64'(rsp_valid_o), 64'd1);
            check("t4_hold_rdata", 64'(rsp_rdata_o), 64'h77);
            check("t4_hold_ready", 64'(cmd_ready_o), 64'd0);
            check("t4_hold_psel",  64'(psel_o),      64'd0);
            @(negedge clk);
        end
        rsp_ready_i = 1'b1;
        wait_rsp("t4a");
        @(negedge clk);
        check("t4_idle_ready", 64'(cmd_ready_o), 64'd1);
        check("t4_idle_psel",  64'(psel_o),      64'd0);
        check("t4_idle_valid", 64'(rsp_valid_o), 64'd0);
        @(negedge clk);
        cmd_valid_i = 1'b0;
        check("t4b_psel",   64'(psel_o),   64'd1);
        check("t4b_paddr",  64'(paddr_o),  64'h030);
        check("t4b_pwrite", 64'(pwrite_o), 64'd1);
        check("t4b_pwdata", 64'(pwdata_o), 64'h1234_5678);
        wait_rsp("t4b");
        @(negedge clk);

        // 5: misaligned address is word-aligned on the bus
        prdata_i = 32'h0000_CAFE;
        drive_cmd(1'b0, 12'h00E, 32'h0, 4'hF);
        sb_q.push_back(rsp_t'{rdata: 32'hCAFE, err: 1'b0});
        @(negedge clk);
        cmd_valid_i = 1'b0;
        check("t5_paddr", 64'(paddr_o), 64'h00C);
        wait_rsp("t5");
        @(negedge clk);

        // 6: reset in the middle of ACCESS
        pready_i = 1'b0;
        drive_cmd(1'b1, 12'h040, 32'h0000_0055, 4'hF);
        @(negedge clk);
        cmd_valid_i = 1'b0;
        @(negedge clk);
        check("t6_access_penable", 64'(penable_o), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_async_psel",    64'(psel_o),    64'd0);
        check("t6_async_penable", 64'(penable_o), 64'd0);
        @(negedge clk);
        reset_n  = 1'b1;
        pready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_no_rsp",    64'(rsp_valid_o), 64'd0);
            check("t6_cmd_ready", 64'(cmd_ready_o), 64'd1);
        end

`ifdef APB_REQUESTER_TIMEOUT_EN
        // 7: completer never answers; error after 16 ACCESS cycles
        pready_i = 1'b0;
        prdata_i = 32'h0000_1111;
        drive_cmd(1'b0, 12'h050, 32'h0, 4'hF);
        sb_q.push_back(rsp_t'{rdata: 32'h0, err: 1'b1});
        @(negedge clk);
        cmd_valid_i = 1'b0;
        n = 0;
        for (int i = 0; i < 100 && rsp_valid_o !== 1'b1; i++) begin
            @(negedge clk);
            if (penable_o === 1'b1) n++;
        end
        check("t7_access_cycles", 64'(n), 64'd16);
        check("t7_psel_dropped",  64'(psel_o), 64'd0);
        wait_rsp("t7");
        pready_i = 1'b1;
        @(negedge clk);
`else
        n = 0;
`endif

        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
- APB4 requester (master) that drives the APB completer side of the UART register block.
- Converts a single-outstanding command/response valid-ready interface from the system controller into compliant APB SETUP/ACCESS transfers.
- Returns read data and error status.
- Sits between the controller and the UART register block. Its psel/penable/pwrite/paddr/pwdata/pstrb connect directly to the block's APB inputs.

Parameters:
ADDR_WIDTH, 12, APB address width; matches the register block's paddr.
DATA_WIDTH, 32, APB data width; strobe width is DATA_WIDTH/8.
TIMEOUT_CYCLES, 16, max ACCESS-phase cycles waiting for pready (used only with the optional feature; must be >= 2).

Ports:
clk  input  1  system clock, rising-edge.
reset_n  input  1  asynchronous active-low reset.
cmd_valid_i  input  1  command present.
cmd_ready_o  output  1  requester can accept a command.
cmd_write_i  input  1  1 = write, 0 = read.
cmd_addr_i  input  ADDR_WIDTH  byte address.
cmd_wdata_i  input  DATA_WIDTH  write data.
cmd_strb_i  input  DATA_WIDTH/8  write byte strobes.
rsp_valid_o  output  1  response available.
rsp_ready_i  input  1  controller accepts response.
rsp_rdata_o  output  DATA_WIDTH  read data (0 for writes).
rsp_error_o  output  1  pslverr seen, or timeout.
psel_o  output  1  APB select.
penable_o  output  1  APB enable.
pwrite_o  output  1  APB direction.
paddr_o  output  ADDR_WIDTH  APB address.
pwdata_o  output  DATA_WIDTH  APB write data.
pstrb_o  output  DATA_WIDTH/8  APB write strobes.
prdata_i  input  DATA_WIDTH  APB read data.
pready_i  input  1  completer ready.
pslverr_i  input  1  completer error.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous active-low, reset_n.
- Reset values:
  - All outputs 0, except cmd_ready_o = 1.
  - State is IDLE.
  - Internal command registers are 0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready_o = 1; psel_o = 0; penable_o = 0.
  - On cmd_valid_i && cmd_ready_o:
    - Latch write, addr, wdata, strb.
    - paddr_o = {cmd_addr_i[ADDR_WIDTH-1:2], 2'b00}; low address bits are dropped, transfers are word-aligned.
    - pstrb_o = cmd_strb_i on writes; forced to all-zero on reads.
    - pwdata_o = cmd_wdata_i on writes; holds its previous value on reads.
    - Go to SETUP.
- SETUP: psel_o = 1, penable_o = 0, cmd_ready_o = 0. Always go to ACCESS next cycle.
- ACCESS:
  - psel_o = 1, penable_o = 1.
  - Stay while pready_i = 0.
  - When pready_i = 1:
    - rsp_rdata_o <= prdata_i for reads, 0 for writes.
    - rsp_error_o <= pslverr_i.
    - Go to RESP.
  - pslverr_i is sampled only in the pready cycle.
- RESP:
  - psel_o = 0, penable_o = 0, rsp_valid_o = 1.
  - rsp_rdata_o and rsp_error_o are held stable.
  - On rsp_ready_i = 1: go to IDLE and clear rsp_valid_o the next cycle.
  - cmd_ready_o stays 0 until IDLE is reached (single outstanding transaction).
- Signal stability:
  - paddr_o, pwrite_o, pwdata_o and pstrb_o are stable from SETUP through the last ACCESS cycle.
  - They keep their last values in IDLE and RESP; they are not cleared.
- Latency: accept at cycle T, SETUP at T+1, ACCESS at T+2. With zero wait states, rsp_valid_o = 1 at T+3.
- Throughput: with rsp_ready_i tied high, the minimum is one transfer per 4 cycles.
- Combinational paths: cmd_ready_o and the APB control outputs are registered or pure state decode. There is no combinational path from pready_i to cmd_ready_o.
- Reset mid-transfer: psel_o and penable_o drop immediately (asynchronously), the FSM returns to IDLE, and no response is produced.
- Boundary conditions:
  - cmd_valid_i asserted outside IDLE is ignored; the command is not consumed until cmd_ready_o = 1.
  - rsp_ready_i asserted while not in RESP has no effect.

Optional Feature:
APB_REQUESTER_TIMEOUT_EN
- Defined: a wait counter clears on SETUP entry and increments each ACCESS cycle with pready_i = 0.
  - When the counter reaches TIMEOUT_CYCLES-1 with pready_i still 0, go to RESP with rsp_error_o = 1 and rsp_rdata_o = 0.
  - psel_o and penable_o drop that same transition.
  - A pready_i arriving in the timeout cycle takes precedence as a normal completion.
- Not defined: no counter logic exists and ACCESS waits indefinitely for pready_i.

Test Plan:
1. Write: cmd addr 0x008, wdata 0x0000_001B, strb 4'hF, pready_i tied 1 -> psel_o high T+1..T+2, penable_o high T+2 only, paddr_o=0x008, pstrb_o=4'hF; rsp_valid_o at T+3 with rsp_error_o=0, rsp_rdata_o=0.
2. Read: cmd addr 0x010, strb 4'hF, prdata_i=0x0000_0005, pready_i=1 -> pstrb_o=0, pwrite_o=0; rsp_rdata_o=0x0000_0005 at T+3.
3. Wait states: pready_i low for 3 ACCESS cycles then high with pslverr_i=1 -> penable_o high 4 cycles, paddr/pwdata stable throughout; rsp_error_o=1.
4. Backpressure: rsp_ready_i low for 5 cycles, second cmd_valid_i held -> rsp_valid_o and data held, cmd_ready_o=0, second command accepted only after IDLE returns.
5. Misaligned address: cmd_addr 0x00E -> paddr_o=0x00C.
6. Reset asserted in ACCESS -> psel_o and penable_o go 0 immediately, cmd_ready_o=1 after release, no rsp_valid_o. With APB_REQUESTER_TIMEOUT_EN and pready_i held 0 -> rsp_error_o=1 after TIMEOUT_CYCLES=16 ACCESS cycles.
